// File: rtl/interrupter_gen.sv
// Interrupter burst generator: tick prescaler, IDLE/ON/OFF period FSM.
// Optional sticky fault latch enabled by INTERRUPTER_FAULT_LATCH_EN.
module interrupter_gen #(
  parameter int TICK_DIV = 500,
  parameter int ON_MAX   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inter_freq,
  input  logic [7:0] inter_duty,
  input  logic       fault,
  output logic       inter_en,
  output logic       period_strb,
  output logic       fault_flag
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] ON_CAP = 8'(ON_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ps_q, ps_d;
  logic [7:0] ds_q, ds_d;
  logic strb_q, strb_d;
  logic lat_q;

  logic tick;
  logic start;
  logic boundary;
  logic [7:0] freq_m1;
  logic [7:0] duty_cap;
  logic [7:0] duty_clip;

`ifdef INTERRUPTER_FAULT_LATCH_EN
  logic lat_d;
  always_comb begin
    lat_d = lat_q | fault;
  end

  always_ff @(posedge clk) begin
    if (rst) lat_q <= 1'b0;
    else     lat_q <= lat_d;
  end
`else
  assign lat_q = 1'b0;
`endif

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // On-time may never reach the full period, so one tick stays off.
  always_comb begin
    freq_m1   = inter_freq - 8'd1;
    duty_cap  = (inter_duty < ON_CAP) ? inter_duty : ON_CAP;
    duty_clip = (duty_cap < freq_m1) ? duty_cap : freq_m1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ps_d     = ps_q;
    ds_d     = ds_q;
    strb_d   = 1'b0;
    start    = 1'b0;
    boundary = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_IDLE: begin
          start = (inter_freq != 8'd0) && !lat_q;
        end
        S_ON: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == ds_q - 8'd1 || fault)
            state_d = S_OFF;
        end
        S_OFF: begin
          if (cnt_q == ps_q - 8'd1) boundary = 1'b1;
          else cnt_d = cnt_q + 8'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_ON && fault) begin
      state_d = S_OFF;
    end
    if (boundary) begin
      if (inter_freq == 8'd0 || lat_q) begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end else begin
        start = 1'b1;
      end
    end
    if (start) begin
      ps_d    = inter_freq;
      ds_d    = duty_clip;
      cnt_d   = 8'd0;
      strb_d  = 1'b1;
      state_d = (duty_clip != 8'd0 && !fault) ? S_ON : S_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= 8'd0;
      ps_q    <= 8'd0;
      ds_q    <= 8'd0;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      ds_q    <= ds_d;
      strb_q  <= strb_d;
    end
  end

  assign inter_en    = (state_q == S_ON) && !rst;
  assign period_strb = strb_q && !rst;
  assign fault_flag  = lat_q && !rst;

endmodule

// File: tb/tb_interrupter_gen.sv
// Bench for interrupter_gen: TICK_DIV=4, ON_MAX=40 plus an ON_MAX=5 copy.
// Period/on-time expectations come from the Ps/Ds rules directly.
module tb_interrupter_gen;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] inter_freq = 8'd0;
  logic [7:0] inter_duty = 8'd0;
  logic fault = 1'b0;
  logic en, strb, flag;
  logic en5, strb5, flag5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  interrupter_gen #(.TICK_DIV(TD), .ON_MAX(40)) u_dut (
    .clk(clk), .rst(rst),
    .inter_freq(inter_freq), .inter_duty(inter_duty),
    .fault(fault),
    .inter_en(en), .period_strb(strb), .fault_flag(flag)
  );

  interrupter_gen #(.TICK_DIV(TD), .ON_MAX(5)) u_dut5 (
    .clk(clk), .rst(rst),
    .inter_freq(inter_freq), .inter_duty(inter_duty),
    .fault(fault),
    .inter_en(en5), .period_strb(strb5), .fault_flag(flag5)
  );

  function automatic int exp_on(int f, int d, int m);
    int r;
    r = d;
    if (m < r) r = m;
    if (f - 1 < r) r = f - 1;
    return r * TD;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_strb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (strb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the strobe clock; returns at the next strobe clock.
  task automatic measure(input int chg_at, input logic [7:0] nf,
                         output int len, output int hi,
                         output int hi5, output bit ok);
    len = 0; hi = 0; hi5 = 0; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (en) hi++;
      if (en5) hi5++;
      len++;
      if (len == chg_at) inter_freq = nf;
      @(negedge clk);
      if (strb) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_cfg(input int f, input int d, input string nm);
    bit ok;
    int len, hi, hi5;
    inter_freq = 8'(f);
    inter_duty = 8'(d);
    wait_strb(ok);
    if (ok) measure(0, 8'd0, len, hi, hi5, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s timeout: no strobe seen, required one", nm);
      return;
    end
    tests++;
    if (len !== f * TD) begin
      fails++;
      $display("FAIL %s len: got %0d required %0d", nm, len, f * TD);
    end
    tests++;
    if (hi !== exp_on(f, d, 40)) begin
      fails++;
      $display("FAIL %s hi40: got %0d required %0d",
               nm, hi, exp_on(f, d, 40));
    end
    tests++;
    if (hi5 !== exp_on(f, d, 5)) begin
      fails++;
      $display("FAIL %s hi5: got %0d required %0d",
               nm, hi5, exp_on(f, d, 5));
    end
  endtask

  task automatic test_reset();
    inter_freq = 8'd10;
    inter_duty = 8'd3;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (en !== 1'b0 || en5 !== 1'b0) begin
      fails++;
      $display("FAIL reset_en: got %b/%b required 0", en, en5);
    end
    tests++;
    if (strb !== 1'b0) begin
      fails++;
      $display("FAIL reset_strb: got %b required 0", strb);
    end
    tests++;
    if (flag !== 1'b0) begin
      fails++;
      $display("FAIL reset_flag: got %b required 0", flag);
    end
  endtask

  task automatic test_disabled();
    int bad;
    int first;
    bit ok;
    int len, hi, hi5;
    inter_freq = 8'd0;
    inter_duty = 8'd3;
    do_reset();
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (strb || en) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL disabled: %0d active clocks, required 0", bad);
    end
    inter_freq = 8'd5;
    inter_duty = 8'd2;
    first = 0;
    for (int i = 1; i <= TD; i++) begin
      @(negedge clk);
      if (strb) begin
        first = i;
        break;
      end
    end
    tests++;
    if (first == 0) begin
      fails++;
      $display("FAIL enable_first: no strobe in %0d clk, required one", TD);
      return;
    end
    measure(0, 8'd0, len, hi, hi5, ok);
    tests++;
    if (!ok || len !== 20 || hi !== 8) begin
      fails++;
      $display("FAIL enable_period: len %0d hi %0d required 20/8", len, hi);
    end
  endtask

  task automatic test_freq_change();
    bit ok;
    int len, hi, hi5;
    inter_freq = 8'd10;
    inter_duty = 8'd3;
    wait_strb(ok);
    if (ok) measure(2, 8'd20, len, hi, hi5, ok);
    tests++;
    if (!ok || len !== 40 || hi !== 12) begin
      fails++;
      $display("FAIL chg_cur: len %0d hi %0d required 40/12", len, hi);
    end
    if (ok) measure(0, 8'd0, len, hi, hi5, ok);
    tests++;
    if (!ok || len !== 80 || hi !== 12) begin
      fails++;
      $display("FAIL chg_next: len %0d hi %0d required 80/12", len, hi);
    end
  endtask

  task automatic test_random();
    int f, d;
    for (int k = 0; k < 10; k++) begin
      f = $urandom_range(1, 12);
      d = $urandom_range(0, 15);
      run_cfg(f, d, $sformatf("rand%0d_f%0d_d%0d", k, f, d));
    end
  endtask

  task automatic test_fault();
    bit ok;
    int len, hi, hi5, bad;
    inter_freq = 8'd10;
    inter_duty = 8'd3;
    wait_strb(ok);
    wait_strb(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL fault_setup: no strobe, required one");
      return;
    end
    @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    tests++;
    if (en !== 1'b0) begin
      fails++;
      $display("FAIL fault_drop: en %b required 0", en);
    end
`ifdef INTERRUPTER_FAULT_LATCH_EN
    tests++;
    if (flag !== 1'b1) begin
      fails++;
      $display("FAIL fault_flag_set: got %b required 1", flag);
    end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (strb || en || !flag) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL fault_latched: %0d bad clocks, required 0", bad);
    end
`else
    tests++;
    if (flag !== 1'b0) begin
      fails++;
      $display("FAIL fault_flag_tied: got %b required 0", flag);
    end
    measure(0, 8'd0, len, hi, hi5, ok);
    tests++;
    if (!ok || len !== 38 || hi !== 0) begin
      fails++;
      $display("FAIL fault_rest: len %0d hi %0d required 38/0", len, hi);
    end
    bad = 0;
    if (ok) measure(0, 8'd0, len, hi, hi5, ok);
    tests++;
    if (!ok || len !== 40 || hi !== 12) begin
      fails++;
      $display("FAIL fault_resume: len %0d hi %0d required 40/12", len, hi);
    end
`endif
  endtask

  task automatic test_reset_mid_on();
    bit ok;
    int first;
    inter_freq = 8'd10;
    inter_duty = 8'd3;
    do_reset();
    wait_strb(ok);
    @(negedge clk);
    tests++;
    if (!ok || en !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_setup: en %b required 1", en);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (en !== 1'b0 || strb !== 1'b0 || flag !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: en %b strb %b flag %b required 000",
               en, strb, flag);
    end
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 2 * TD; i++) begin
      @(negedge clk);
      if (strb) begin
        first = i;
        break;
      end
    end
    tests++;
    if (first !== TD) begin
      fails++;
      $display("FAIL rst_restart: strobe at clk %0d required %0d", first, TD);
    end
  endtask

  initial begin
    test_reset();
    test_disabled();
    run_cfg(10, 3, "basic");
    run_cfg(10, 20, "clip");
    run_cfg(1, 5, "ps1");
    run_cfg(6, 0, "duty0");
    test_freq_change();
    test_random();
    test_fault();
    test_reset_mid_on();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
